// File: rtl/adc_seq_pkg.sv
// Shared types and helpers for the ADC scan sequencer: FSM states, width
// derivations and the averaging sample-count decode.
package adc_seq_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SETTLE,
        SOC,
        WAIT_EOC,
        ACCUM,
        NEXT,
        WAIT_PER
    } state_e;

    // Guard bits so eight full-scale samples sum without overflow.
    localparam int ACC_GUARD = 3;

    function automatic int ch_w(input int nch);
        return (nch > 2) ? $clog2(nch) : 1;
    endfunction

    function automatic int acc_w(input int dw);
        return dw + ACC_GUARD;
    endfunction

    function automatic logic [3:0] avg_count(input logic [1:0] avg_log2);
        return 4'd1 << avg_log2;
    endfunction

endpackage

// File: rtl/adc_seq_chsel.sv
// Priority finder: lowest enabled channel strictly above cur_i, or the lowest
// enabled channel overall when first_i is set; none_o flags an empty result.
module adc_seq_chsel #(
    parameter int NCH = 8,
    parameter int CW  = 3
) (
    input  logic [NCH-1:0] mask_i,
    input  logic [CW-1:0]  cur_i,
    input  logic           first_i,
    output logic [CW-1:0]  nxt_o,
    output logic           none_o
);

    always_comb begin
        nxt_o  = '0;
        none_o = 1'b1;
        // Scan downward so the lowest qualifying channel is the last assignment.
        for (int i = NCH - 1; i >= 0; i--) begin
            if (mask_i[i] && (first_i || (i > int'(cur_i)))) begin
                nxt_o  = CW'(i);
                none_o = 1'b0;
            end
        end
    end

endmodule

// File: rtl/adc_seq_ctrl.sv
// Multi-channel scan sequencer in front of the SAR controller: steps the mux,
// settles, converts, optionally averages, and fills one result per channel.
module adc_seq_ctrl
    import adc_seq_pkg::*;
#(
    parameter int NCH    = 8,
    parameter int DW     = 8,
    parameter int CW     = ch_w(NCH),
    parameter int TW     = 16,
    parameter int TO_CYC = DW + 6
) (
    input  logic           clk,
    input  logic           rstn,
    input  logic           en,
    input  logic           start,
    input  logic [NCH-1:0] ch_mask,
    input  logic [TW-1:0]  period,
    input  logic [3:0]     settle,
    input  logic [1:0]     avg_log2,
    input  logic           clr,
    output logic           adc_soc,
    input  logic           adc_eoc,
    input  logic [DW-1:0]  adc_data,
    output logic [CW-1:0]  mux_sel,
    output logic           busy,
    output logic           scan_done,
    output logic           err_timeout,
    input  logic [CW-1:0]  res_rd_ch,
    output logic [DW-1:0]  res_rd_data,
    output logic [NCH-1:0] res_valid
);

    localparam int ACC_W = acc_w(DW);
    localparam int TOW   = $clog2(TO_CYC + 1);
    localparam logic [TOW-1:0] TO_LAST = TOW'(TO_CYC - 1);

    state_e           state_q;
    logic [NCH-1:0]   mask_q;
    logic [1:0]       avg_q;
    logic [CW-1:0]    mux_sel_q;
    logic             adc_soc_q;
    logic             busy_q;
    logic             scan_done_q;
    logic             err_q;
    logic [3:0]       set_q;
    logic [TOW-1:0]   to_q;
    logic [3:0]       smp_q;
    logic [ACC_W-1:0] acc_q;
    logic             skip_q;
    logic [TW-1:0]    timer_q;
    logic [TW-1:0]    timer_d;
    logic [DW-1:0]    res_q [NCH];
    logic [NCH-1:0]   res_valid_q;

    logic             launch;
    logic             launch_go;
    logic             sel_first;
    logic [NCH-1:0]   sel_mask;
    logic [CW-1:0]    nxt_ch;
    logic             nxt_none;
    logic             wr_en;
    logic [DW-1:0]    res_val;
    logic [ACC_W-1:0] acc_sum;
    logic             settle_done;

    assign launch      = (start | (en & (timer_q == '0))) & (|ch_mask);
    assign launch_go   = launch & ((state_q == IDLE) | (state_q == WAIT_PER));
    assign sel_first   = (state_q == IDLE) | (state_q == WAIT_PER);
    assign sel_mask    = sel_first ? ch_mask : mask_q;
    assign wr_en       = (state_q == NEXT) & ~skip_q;
    assign res_val     = DW'(acc_q >> avg_q);
    assign acc_sum     = acc_q + ACC_W'(adc_data);
    assign settle_done = ({1'b0, set_q} + 5'd1) >= {1'b0, settle};

    adc_seq_chsel #(
        .NCH (NCH),
        .CW  (CW)
    ) u_chsel (
        .mask_i  (sel_mask),
        .cur_i   (mux_sel_q),
        .first_i (sel_first),
        .nxt_o   (nxt_ch),
        .none_o  (nxt_none)
    );

    // Loading period-1 counts the launch cycle itself, so launches land exactly
    // `period` cycles apart; zero keeps the timer expired for back-to-back scans.
    always_comb begin
        timer_d = timer_q;
        if (launch_go) begin
            timer_d = (period == '0) ? '0 : period - TW'(1);
        end else if (timer_q != '0) begin
            timer_d = timer_q - TW'(1);
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            timer_q <= '0;
        end else begin
            timer_q <= timer_d;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q     <= IDLE;
            mask_q      <= '0;
            avg_q       <= '0;
            mux_sel_q   <= '0;
            adc_soc_q   <= 1'b0;
            busy_q      <= 1'b0;
            scan_done_q <= 1'b0;
            err_q       <= 1'b0;
            set_q       <= '0;
            to_q        <= '0;
            smp_q       <= '0;
            acc_q       <= '0;
            skip_q      <= 1'b0;
        end else begin
            adc_soc_q   <= 1'b0;
            scan_done_q <= 1'b0;
            if (clr) begin
                err_q <= 1'b0;
            end
            case (state_q)
                IDLE, WAIT_PER: begin
                    if (launch) begin
                        mask_q    <= ch_mask;
                        avg_q     <= avg_log2;
                        mux_sel_q <= nxt_ch;
                        busy_q    <= 1'b1;
                        set_q     <= '0;
                        acc_q     <= '0;
                        smp_q     <= '0;
                        skip_q    <= 1'b0;
                        state_q   <= SETTLE;
                    end else if ((state_q == WAIT_PER) && !en) begin
                        state_q <= IDLE;
                    end
                end
                SETTLE: begin
                    if (settle_done) begin
                        adc_soc_q <= 1'b1;
                        state_q   <= SOC;
                    end else begin
                        set_q <= set_q + 4'd1;
                    end
                end
                SOC: begin
                    to_q    <= '0;
                    state_q <= WAIT_EOC;
                end
                WAIT_EOC: begin
                    if (adc_eoc) begin
                        acc_q   <= acc_sum;
                        smp_q   <= smp_q + 4'd1;
                        state_q <= ACCUM;
                    end else if (to_q == TO_LAST) begin
                        // A timed-out channel drops every sample gathered so far.
                        err_q   <= 1'b1;
                        skip_q  <= 1'b1;
                        state_q <= NEXT;
                    end else begin
                        to_q <= to_q + TOW'(1);
                    end
                end
                ACCUM: begin
                    if (smp_q < avg_count(avg_q)) begin
                        adc_soc_q <= 1'b1;
                        state_q   <= SOC;
                    end else begin
                        state_q <= NEXT;
                    end
                end
                NEXT: begin
                    acc_q  <= '0;
                    smp_q  <= '0;
                    skip_q <= 1'b0;
                    if (!nxt_none) begin
                        mux_sel_q <= nxt_ch;
                        set_q     <= '0;
                        state_q   <= SETTLE;
                    end else begin
                        scan_done_q <= 1'b1;
                        busy_q      <= 1'b0;
                        state_q     <= en ? WAIT_PER : IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // A result write on the same cycle as clr keeps its own valid bit.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < NCH; i++) begin
                res_q[i] <= '0;
            end
            res_valid_q <= '0;
        end else begin
            if (clr) begin
                res_valid_q <= '0;
            end
            if (wr_en) begin
                res_q[mux_sel_q]       <= res_val;
                res_valid_q[mux_sel_q] <= 1'b1;
            end
        end
    end

    assign adc_soc     = adc_soc_q;
    assign mux_sel     = mux_sel_q;
    assign busy        = busy_q;
    assign scan_done   = scan_done_q;
    assign err_timeout = err_q;
    assign res_valid   = res_valid_q;
    assign res_rd_data = res_q[res_rd_ch];

endmodule
